// File: rtl/output_display_pkg.sv
// Shared types and constants for the CPU output-register display.
// Optional feature macro: OUTPUT_DISPLAY_SIGNED_EN (two's-complement value with minus sign).
package output_display_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // gfedcba patterns for digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [2:0] SEL_ONES     = 3'b001;
  localparam logic [2:0] SEL_TENS     = 3'b010;
  localparam logic [2:0] SEL_HUNDREDS = 3'b100;

  localparam logic [2:0] LAST_STEP = 3'd7;

  // Double-dabble pre-shift correction: +3 on every BCD nibble >= 5.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/output_display_if.sv
// CPU-to-display bundle: output register and halt flag in, multiplexed
// segment drive, busy and FSM state out.
interface output_display_if;
  import output_display_pkg::*;

  logic [7:0] value;
  logic       halted;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] digit_sel;
  logic       busy;
  state_t     state;

  // No handshake: value/halted are level inputs sampled every clk edge,
  // and every output is a continuously valid level.
  modport master (
    output value, halted,
    input  seg, dp, digit_sel, busy, state
  );

  modport slave (
    input  value, halted,
    output seg, dp, digit_sel, busy, state
  );
endinterface

// File: rtl/output_display_seg7_decoder.sv
// Combinational BCD digit to 7-segment (gfedcba, active-high) decoder.
// Codes 10..15 blank the display.
module seg7_decoder
  import output_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0: seg = SEG_LUT[0];
      4'd1: seg = SEG_LUT[1];
      4'd2: seg = SEG_LUT[2];
      4'd3: seg = SEG_LUT[3];
      4'd4: seg = SEG_LUT[4];
      4'd5: seg = SEG_LUT[5];
      4'd6: seg = SEG_LUT[6];
      4'd7: seg = SEG_LUT[7];
      4'd8: seg = SEG_LUT[8];
      4'd9: seg = SEG_LUT[9];
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/output_display.sv
// Three-digit multiplexed display of the CPU output register: 8-cycle
// double-dabble conversion plus free-running digit scan. Macro: OUTPUT_DISPLAY_SIGNED_EN.
module output_display
  import output_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset,
  output_display_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    shown_q, shift_q, mag;
  logic [11:0]   bcd_q;
  logic [2:0]    iter_q;
  logic [3:0]    ones_q, tens_q, hund_q, digit_cur;
  logic [19:0]   dd_next;
  logic [PW-1:0] presc_q;
  logic [2:0]    sel_q;
  logic          halted_q;
  logic          load, step, done;
  logic [6:0]    seg_raw;

`ifdef OUTPUT_DISPLAY_SIGNED_EN
  logic sign_pend_q, sign_q;
  // -128 negates to itself, which reads correctly as unsigned 128
  assign mag = bus.value[7] ? (~bus.value + 8'd1) : bus.value;
`else
  assign mag = bus.value;
`endif

  assign dd_next = {dd_adjust(bcd_q), shift_q} << 1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.value != shown_q) begin
          load    = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        step = 1'b1;
        if (iter_q == LAST_STEP) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_q <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else if (load) begin
      shown_q <= bus.value;
      shift_q <= mag;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else if (step) begin
      {bcd_q, shift_q} <= dd_next;
      iter_q           <= iter_q + 3'd1;
      // Digits only ever move here, so a partial result is never shown
      if (done) begin
        hund_q <= dd_next[19:16];
        tens_q <= dd_next[15:12];
        ones_q <= dd_next[11:8];
      end
    end
  end

`ifdef OUTPUT_DISPLAY_SIGNED_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      if (load) sign_pend_q <= bus.value[7];
      if (done) sign_q      <= sign_pend_q;
    end
  end
`endif

  // Scan runs regardless of conversion activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      sel_q    <= SEL_ONES;
      halted_q <= 1'b0;
    end else begin
      halted_q <= bus.halted;
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
        sel_q   <= {sel_q[1:0], sel_q[2]};
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    digit_cur = ones_q;
    case (sel_q)
      SEL_TENS:     digit_cur = tens_q;
      SEL_HUNDREDS: digit_cur = hund_q;
      default:      digit_cur = ones_q;
    endcase
  end

  seg7_decoder u_dec (
    .digit (digit_cur),
    .seg   (seg_raw)
  );

`ifdef OUTPUT_DISPLAY_SIGNED_EN
  assign bus.seg = (sel_q == SEL_HUNDREDS && sign_q && hund_q == 4'd0) ? SEG_MINUS : seg_raw;
`else
  assign bus.seg = seg_raw;
`endif

  assign bus.dp        = halted_q & (sel_q == SEL_ONES);
  assign bus.digit_sel = sel_q;
  assign bus.busy      = (state_q == CONVERT);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display with REFRESH_DIV = 4 (12-cycle scan).
// Build with OUTPUT_DISPLAY_SIGNED_EN defined to exercise the signed variant.
module tb_output_display;
  import output_display_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  output_display_if bus();

  output_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Records the pattern shown at each digit position over one full scan.
  task automatic capture_segs(output logic [6:0] s_ones, output logic [6:0] s_tens,
                              output logic [6:0] s_hund);
    s_ones = 'x; s_tens = 'x; s_hund = 'x;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (bus.digit_sel)
        3'b001: s_ones = bus.seg;
        3'b010: s_tens = bus.seg;
        3'b100: s_hund = bus.seg;
        default: ;
      endcase
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [6:0] so, st, sh;
    int busy_seen;
    bus.value = 8'd0; bus.halted = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.seg !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h expected 3f", bus.seg); end
    checks++; if (bus.dp !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b expected 0", bus.dp); end
    checks++; if (bus.digit_sel !== 3'b001) begin errors++; $display("FAIL reset_sel: got %b expected 001", bus.digit_sel); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", bus.state); end
    reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL idle_no_busy: got %0d busy cycles expected 0", busy_seen); end
    capture_segs(so, st, sh);
    checks++; if (so !== 7'h3F) begin errors++; $display("FAIL idle_ones: got %h expected 3f", so); end
    checks++; if (st !== 7'h3F) begin errors++; $display("FAIL idle_tens: got %h expected 3f", st); end
    checks++; if (sh !== 7'h3F) begin errors++; $display("FAIL idle_hund: got %h expected 3f", sh); end
  endtask

  task automatic test_convert_137;
    logic [6:0] so, st, sh;
    bit ok;
    int n, partial_bad;
    @(negedge clk);
    bus.value = 8'd137;
    wait_busy(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL c137_start: got busy=%b expected 1", ok); end
    checks++; if (bus.state !== CONVERT) begin errors++; $display("FAIL c137_state: got %0d expected CONVERT", bus.state); end
    n = 1; partial_bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.seg !== 7'h3F) partial_bad++;
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL c137_busy_len: got %0d expected 8", n); end
    checks++; if (partial_bad !== 0) begin errors++; $display("FAIL c137_partial: got %0d changed cycles expected 0", partial_bad); end
    capture_segs(so, st, sh);
    checks++; if (so !== 7'h07) begin errors++; $display("FAIL c137_ones: got %h expected 07", so); end
    checks++; if (st !== 7'h4F) begin errors++; $display("FAIL c137_tens: got %h expected 4f", st); end
    checks++; if (sh !== 7'h06) begin errors++; $display("FAIL c137_hund: got %h expected 06", sh); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] so, st, sh, exp;
    bit ok;
    int n, bad;
    @(negedge clk);
    bus.value = 8'd255;
    wait_busy(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_start: got busy=%b expected 1", ok); end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      if (n == 4) bus.value = 8'd42;
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL b2b_first_len: got %0d expected 8", n); end
    // 255 shows as 2/5/5 until the 42 conversion completes
    exp = (bus.digit_sel == 3'b100) ? 7'h5B : 7'h6D;
    checks++; if (bus.seg !== exp) begin errors++; $display("FAIL b2b_255_shown: got %h expected %h", bus.seg, exp); end
    wait_busy(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got busy=%b expected 1", ok); end
    n = 1; bad = 0;
    for (int i = 0; i < 30; i++) begin
      exp = (bus.digit_sel == 3'b100) ? 7'h5B : 7'h6D;
      if (bus.seg !== exp) bad++;
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL b2b_second_len: got %0d expected 8", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_hold_255: got %0d wrong cycles expected 0", bad); end
    capture_segs(so, st, sh);
    checks++; if (so !== 7'h5B) begin errors++; $display("FAIL b2b_ones: got %h expected 5b", so); end
    checks++; if (st !== 7'h66) begin errors++; $display("FAIL b2b_tens: got %h expected 66", st); end
    checks++; if (sh !== 7'h3F) begin errors++; $display("FAIL b2b_hund: got %h expected 3f", sh); end
  endtask

  task automatic test_refresh;
    logic [2:0] cur, exp_next;
    int len, bad, dp_seen;
    bit found;
    bus.halted = 1'b0;
    cur = bus.digit_sel; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.digit_sel !== cur) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL refresh_sync: got no digit_sel change expected one within 10 cycles"); end
    for (int k = 0; k < 3; k++) begin
      cur = bus.digit_sel;
      case (cur)
        3'b001:  exp_next = 3'b010;
        3'b010:  exp_next = 3'b100;
        default: exp_next = 3'b001;
      endcase
      len = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        len++;
        if (bus.digit_sel !== cur) break;
      end
      checks++; if (len !== 4) begin errors++; $display("FAIL refresh_period: got %0d expected 4", len); end
      checks++; if (bus.digit_sel !== exp_next) begin errors++; $display("FAIL refresh_order: got %b expected %b", bus.digit_sel, exp_next); end
    end
    bus.halted = 1'b1;
    @(negedge clk);
    bad = 0; dp_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dp !== (bus.digit_sel == 3'b001)) bad++;
      if (bus.dp === 1'b1) dp_seen++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL dp_only_ones: got %0d wrong cycles expected 0", bad); end
    checks++; if (dp_seen !== 4) begin errors++; $display("FAIL dp_lit_cycles: got %0d expected 4", dp_seen); end
    bus.halted = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_value(input logic [7:0] v, input logic [6:0] e_hund,
                            input logic [6:0] e_tens, input logic [6:0] e_ones);
    logic [6:0] so, st, sh;
    bit ok;
    int n;
    @(negedge clk);
    bus.value = v;
    wait_busy(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL val_%h_start: got busy=%b expected 1", v, ok); end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL val_%h_len: got %0d expected 8", v, n); end
    capture_segs(so, st, sh);
    checks++; if (so !== e_ones) begin errors++; $display("FAIL val_%h_ones: got %h expected %h", v, so, e_ones); end
    checks++; if (st !== e_tens) begin errors++; $display("FAIL val_%h_tens: got %h expected %h", v, st, e_tens); end
    checks++; if (sh !== e_hund) begin errors++; $display("FAIL val_%h_hund: got %h expected %h", v, sh, e_hund); end
  endtask

  task automatic test_reset_abort;
    logic [6:0] so, st, sh;
    bit ok;
    int n, busy_seen;
    @(negedge clk);
    bus.value = 8'd200;
    wait_busy(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_start: got busy=%b expected 1", ok); end
    n = 1;
    while (n < 5) begin
      @(negedge clk);
      n++;
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d expected IDLE", bus.state); end
    checks++; if (bus.digit_sel !== 3'b001) begin errors++; $display("FAIL abort_sel: got %b expected 001", bus.digit_sel); end
    checks++; if (bus.seg !== 7'h3F) begin errors++; $display("FAIL abort_seg: got %h expected 3f", bus.seg); end
    bus.value = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL abort_no_restart: got %0d busy cycles expected 0", busy_seen); end
    capture_segs(so, st, sh);
    checks++; if (so !== 7'h3F) begin errors++; $display("FAIL abort_ones: got %h expected 3f", so); end
    checks++; if (st !== 7'h3F) begin errors++; $display("FAIL abort_tens: got %h expected 3f", st); end
    checks++; if (sh !== 7'h3F) begin errors++; $display("FAIL abort_hund: got %h expected 3f", sh); end
  endtask

  initial begin
    test_reset;
    test_convert_137;
    test_back_to_back;
    test_refresh;
`ifdef OUTPUT_DISPLAY_SIGNED_EN
    test_value(8'hF6, 7'h40, 7'h06, 7'h3F);
    test_value(8'h80, 7'h06, 7'h5B, 7'h7F);
`else
    test_value(8'hF6, 7'h5B, 7'h66, 7'h7D);
    test_value(8'h80, 7'h06, 7'h5B, 7'h7F);
`endif
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 Parameter REFRESH_DIV, default 1024, is the number of clk cycles each digit is held before the multiplexer advances; legal range is 2..65536.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 value  input  8  output-register contents from the CPU, sampled synchronously.
REQ-005 halted  input  1  CPU halt flag, sampled synchronously.
REQ-006 seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}, active-high.
REQ-007 dp  output  1  decimal point, active-high.
REQ-008 digit_sel  output  3  one-hot digit enable, active-high: bit0 = ones, bit1 = tens, bit2 = hundreds.
REQ-009 busy  output  1  high while a conversion is in progress.

Function
REQ-010 The block SHALL hold a shown register holding the last value accepted for conversion.
REQ-011 The FSM SHALL have exactly two states, IDLE and CONVERT.
REQ-012 IDLE to CONVERT: at an edge in IDLE where value != shown, the block SHALL load value into shown and into the shift register, clear the BCD accumulator, and set the iteration counter to 0.
REQ-013 Each CONVERT edge SHALL do one double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, shift register} left by one.
REQ-014 After the 8th CONVERT edge the block SHALL return to IDLE, and the hundreds, tens and ones digit registers SHALL take the final BCD result on that same edge.
REQ-015 Latency from the capture edge to updated digits SHALL be exactly 8 clk edges; busy SHALL be high during exactly those 8 cycles.
REQ-016 A change of value during CONVERT SHALL NOT abort the conversion; it is re-compared in IDLE and converted next, so only the newest value is converted.
REQ-017 Digit registers SHALL NOT change outside the completion edge, so the display never shows a partial result.
REQ-018 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on each wrap, digit_sel SHALL rotate 001 -> 010 -> 100 -> 001.
REQ-019 seg SHALL be the combinational 7-segment pattern of the digit chosen by digit_sel, using 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, gfedcba).
REQ-020 dp SHALL equal a registered copy of halted while digit_sel = 001, and SHALL be 0 otherwise.
REQ-021 The conversion FSM and the multiplexer SHALL run independently; a conversion SHALL NOT stall or reset the prescaler.

Reset
REQ-022 While reset is high, the following SHALL hold: FSM = IDLE, shown = 0, digits = 0, prescaler = 0, digit_sel = 001, busy = 0, halted copy = 0.
REQ-023 It follows that seg = 7'h3F and dp = 0 during reset.
REQ-024 A reset asserted during CONVERT SHALL abort the conversion with no digit update.
REQ-025 After reset release with value = 0, no conversion SHALL start.

Configuration
REQ-026 Macro OUTPUT_DISPLAY_SIGNED_EN: when defined, value is two's complement; the block SHALL convert |value|, with -128 converting as 128.
REQ-027 With the macro defined, a negative value SHALL also set a registered sign flag, updated at the completion edge, that lights segment g only in place of a hundreds digit of 0.
REQ-028 When the macro is undefined, value SHALL be unsigned 0..255 and no sign logic SHALL exist.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the 10-entry segment lookup constants and the digit_sel one-hot constants.
REQ-030 One combinational sub-module, seg7_decoder (4-bit digit in, 7-bit seg out), SHALL be used; the conversion and the multiplexer stay in output_display.

Verification
REQ-031 Reset, hold value = 0 for 20 cycles -> busy never high, digits 0/0/0, seg = 3F.
REQ-032 value 0 -> 137 -> busy high for exactly 8 cycles, then digits 1/3/7 and seg = 06/4F/07 as digit_sel cycles.
REQ-033 value 255, changed to 42 on the 4th busy cycle -> digits 2/5/5 first, then a second 8-cycle conversion to 0/4/2.
REQ-034 REFRESH_DIV = 4 -> digit_sel changes every 4 cycles in the order 001, 010, 100, 001; dp = 1 only on 001 once halted = 1.
REQ-035 Reset pulse on the 5th busy cycle of a conversion to 200 -> digits 0/0/0, busy = 0, with no clk edge needed to clear.
REQ-036 With OUTPUT_DISPLAY_SIGNED_EN: value 8'hF6 -> digits 0/1/0 with hundreds seg = 40; value 8'h80 -> digits 1/2/8, sign flag set.
